mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Bus-master sequencer that drives the 8-bit x 256-word data memory's write/read port: addr, wr_en, rd_en, dat_in; consumes the combinational dat_out.
- On a start request, copies len bytes from src_addr to dst_addr, one byte at a time, and accumulates an 8-bit checksum of the bytes moved.
- Sits beside the core and arbitrates nothing; the top level muxes its memory signals onto the data memory while busy=1.

Parameters:
- AW, 8, address width; the memory is 2**AW words deep.
- DW, 8, data word width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a transfer; sampled only in IDLE.
- src_addr  input  AW  first source address; captured with start.
- dst_addr  input  AW  first destination address; captured with start.
- len  input  AW  byte count; 0 = no transfer; captured with start.
- busy  output  1  high from the cycle after start acceptance through the DONE cycle.
- done  output  1  one-cycle pulse marking completion.
- checksum  output  DW  sum mod 2**DW of all bytes copied; held until the next accepted start.
- mem_addr  output  AW  to memory addr.
- mem_rd_en  output  1  to memory rd_en.
- mem_wr_en  output  1  to memory wr_en.
- mem_wdata  output  DW  to memory dat_in.
- mem_rdata  input  DW  from memory dat_out; combinational read of core[mem_addr].

Behaviour:
- Reset: state=IDLE; busy=0, done=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, checksum=0; internal src/dst/remaining/hold registers=0.
- All outputs decode from registered state only; there is no combinational path from inputs to outputs.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - start=1 and len!=0: capture src, dst and len; clear checksum; go to READ.
  - start=1 and len=0: clear checksum; go to DONE. No memory access occurs.
- READ:
  - Drive mem_addr=src and mem_rd_en=1.
  - At the edge: hold<=mem_rdata, checksum<=checksum+mem_rdata (mod 2**DW), src<=src+1 (wraps 0xFF->0x00); go to WRITE.
- WRITE:
  - Drive mem_addr=dst, mem_wr_en=1, mem_wdata=hold. The memory commits at this edge.
  - At the edge: dst<=dst+1 (wraps), remaining<=remaining-1.
  - Go to DONE if remaining was 1, else READ.
- DONE: done=1 for exactly one cycle; go to IDLE.
- busy=1 in READ, WRITE and DONE.
- Latency: start accepted at edge T0 puts done high in cycle T0+2*len+1. len=0 gives done in cycle T0+1.
- Throughput: 2 cycles per byte.
- mem_rd_en and mem_wr_en are never high together.
- In READ and WRITE, mem_wdata holds the last hold value. mem_addr holds its last value in IDLE and DONE.
- start while busy: ignored. The new src/dst/len are not captured and the transfer in progress is unaffected.
- start held high continuously: a new transfer is accepted in the first IDLE cycle after DONE.
- Overlap: strictly forward, byte-serial copy; no memmove semantics.
  - If dst lies in (src, src+len), already-written bytes are re-read. Example: dst=src+1 replicates byte src across the range.
  - src==dst: every byte is rewritten with its own value.
- Address wrap: src and dst wrap mod 2**AW independently. len up to 255 is legal.
- Reset mid-transfer: state returns to IDLE at that edge.
  - If the state was WRITE, that edge's write still commits because the memory samples the same edge.
  - No further accesses follow; done is not pulsed; checksum returns to 0.

Test Plan:
- Basic copy: mem[0x10..0x13]=0x01,0x02,0x03,0x04; start src=0x10 dst=0x80 len=4 -> mem[0x80..0x83]=01,02,03,04; done high exactly 9 cycles after the accept edge; checksum=0x0A; busy low after done.
- len=0: start src=0x20 dst=0x40 len=0 -> done in the next cycle; mem_wr_en and mem_rd_en never asserted; checksum=0.
- Wrap and checksum overflow: mem[0xFE]=0xFF, mem[0xFF]=0xFF, mem[0x00]=0x03; start src=0xFE dst=0x7F len=3 -> mem[0x7F]=0xFF, mem[0x80]=0xFF, mem[0x81]=0x03; checksum=0x01.
- Overlap forward: mem[0x30..0x33]=0xAA,0xBB,0xCC,0xDD; start src=0x30 dst=0x31 len=3 -> mem[0x30..0x33]=AA,AA,AA,AA.
- Start while busy: during a len=4 transfer, pulse start with src=0x00 dst=0x00 len=1 -> ignored; original destination correct; exactly one done pulse.
- Reset mid-op: assert reset in the WRITE cycle of byte 2 of a len=4 copy -> bytes 1-2 written, bytes 3-4 untouched; busy=0, done=0, checksum=0 the cycle after; a following start works normally.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Byte-serial memory copy sequencer: reads src, writes dst, two cycles per byte,
// and accumulates an 8-bit checksum of the bytes moved.
module mem_copy_engine #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW-1:0] remaining;
  logic [DW-1:0] hold;

  // The write data bus is the hold register itself, so it is stable in both
  // READ (previous byte) and WRITE (byte just read).
  assign mem_wdata = hold;

  // Memory control outputs are registered alongside the next state, so each
  // one is valid for the whole cycle of the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      hold      <= '0;
      checksum  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            checksum <= '0;
            busy     <= 1'b1;
            if (len != '0) begin
              src       <= src_addr;
              dst       <= dst_addr;
              remaining <= len;
              mem_addr  <= src_addr;
              mem_rd_en <= 1'b1;
              state     <= READ;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        READ: begin
          hold      <= mem_rdata;
          checksum  <= checksum + mem_rdata;
          src       <= src + 1'b1;
          mem_addr  <= dst;
          mem_rd_en <= 1'b0;
          mem_wr_en <= 1'b1;
          state     <= WRITE;
        end
        WRITE: begin
          dst       <= dst + 1'b1;
          remaining <= remaining - 1'b1;
          mem_wr_en <= 1'b0;
          if (remaining == AW'(1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            mem_addr  <= src;
            mem_rd_en <= 1'b1;
            state     <= READ;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 256-byte behavioural memory and
// hand-computed expectations for data, checksum, latency and control pulses.
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] src_addr, dst_addr, len;
  logic       busy, done;
  logic [7:0] checksum, mem_addr, mem_wdata, mem_rdata;
  logic       mem_rd_en, mem_wr_en;

  // Bench-side preload port so the memory array has a single writer.
  logic       tb_we = 1'b0;
  logic [7:0] tb_waddr = '0, tb_wdata = '0;
  logic [7:0] mem [0:255];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  int snap_done, snap_rd, snap_wr, cyc;

  always #5 clk = ~clk;

  mem_copy_engine #(.AW(8), .DW(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .checksum(checksum),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_waddr] <= tb_wdata;
  end

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (mem_wr_en) wr_cnt <= wr_cnt + 1;
    if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    step();
    tb_we = 1'b0;
  endtask

  // Returns with the bench in the cycle just after the accept edge.
  task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    start = 1'b1; src_addr = s; dst_addr = d; len = l;
    step();
    start = 1'b0;
  endtask

  // Counts cycles from the first post-accept cycle until done is seen.
  task automatic wait_done(output int c);
    c = 0;
    while (!done && c < 600) begin
      step();
      c++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_checksum", checksum, 0);
    reset = 1'b0;
    step();

    // Basic copy
    poke(8'h10, 8'h01); poke(8'h11, 8'h02); poke(8'h12, 8'h03); poke(8'h13, 8'h04);
    snap_done = done_cnt;
    launch(8'h10, 8'h80, 8'd4);
    check("basic_busy", busy, 1);
    check("basic_rd_first", mem_rd_en, 1);
    check("basic_addr_first", mem_addr, 8'h10);
    wait_done(cyc);
    check("basic_latency", cyc, 8);
    check("basic_checksum", checksum, 8'h0A);
    step();
    check("basic_busy_after", busy, 0);
    check("basic_done_after", done, 0);
    check("basic_done_pulses", done_cnt - snap_done, 1);
    check("basic_m80", mem[8'h80], 8'h01);
    check("basic_m81", mem[8'h81], 8'h02);
    check("basic_m82", mem[8'h82], 8'h03);
    check("basic_m83", mem[8'h83], 8'h04);
    check("basic_checksum_held", checksum, 8'h0A);

    // len = 0
    snap_rd = rd_cnt; snap_wr = wr_cnt;
    launch(8'h20, 8'h40, 8'd0);
    wait_done(cyc);
    check("len0_latency", cyc, 0);
    check("len0_checksum", checksum, 8'h00);
    step(); step();
    check("len0_busy_after", busy, 0);
    check("len0_no_rd", rd_cnt - snap_rd, 0);
    check("len0_no_wr", wr_cnt - snap_wr, 0);

    // Address wrap and checksum overflow
    poke(8'hFE, 8'hFF); poke(8'hFF, 8'hFF); poke(8'h00, 8'h03);
    launch(8'hFE, 8'h7F, 8'd3);
    wait_done(cyc);
    check("wrap_latency", cyc, 6);
    check("wrap_checksum", checksum, 8'h01);
    step();
    check("wrap_m7f", mem[8'h7F], 8'hFF);
    check("wrap_m80", mem[8'h80], 8'hFF);
    check("wrap_m81", mem[8'h81], 8'h03);

    // Forward overlap replicates the first byte
    poke(8'h30, 8'hAA); poke(8'h31, 8'hBB); poke(8'h32, 8'hCC); poke(8'h33, 8'hDD);
    launch(8'h30, 8'h31, 8'd3);
    wait_done(cyc);
    check("ovl_checksum", checksum, 8'hFE);
    step();
    check("ovl_m30", mem[8'h30], 8'hAA);
    check("ovl_m31", mem[8'h31], 8'hAA);
    check("ovl_m32", mem[8'h32], 8'hAA);
    check("ovl_m33", mem[8'h33], 8'hAA);

    // Start while busy is ignored
    poke(8'h50, 8'h11); poke(8'h51, 8'h22); poke(8'h52, 8'h33); poke(8'h53, 8'h44);
    snap_done = done_cnt;
    launch(8'h50, 8'h90, 8'd4);
    step(); step();
    start = 1'b1; src_addr = 8'h00; dst_addr = 8'h00; len = 8'd1;
    step();
    start = 1'b0;
    wait_done(cyc);
    check("busy_start_latency", cyc + 3, 8);
    check("busy_start_checksum", checksum, 8'hAA);
    repeat (4) step();
    check("busy_start_pulses", done_cnt - snap_done, 1);
    check("busy_start_idle", busy, 0);
    check("busy_start_m90", mem[8'h90], 8'h11);
    check("busy_start_m91", mem[8'h91], 8'h22);
    check("busy_start_m92", mem[8'h92], 8'h33);
    check("busy_start_m93", mem[8'h93], 8'h44);

    // Reset in the WRITE cycle of byte 2
    poke(8'hA0, 8'h05); poke(8'hA1, 8'h06); poke(8'hA2, 8'h07); poke(8'hA3, 8'h08);
    poke(8'hC0, 8'hEE); poke(8'hC1, 8'hEE); poke(8'hC2, 8'hEE); poke(8'hC3, 8'hEE);
    snap_done = done_cnt;
    launch(8'hA0, 8'hC0, 8'd4);
    step(); step(); step();
    check("rmid_in_write", mem_wr_en, 1);
    check("rmid_write_addr", mem_addr, 8'hC1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rmid_busy", busy, 0);
    check("rmid_done", done, 0);
    check("rmid_checksum", checksum, 0);
    check("rmid_rd_en", mem_rd_en, 0);
    check("rmid_wr_en", mem_wr_en, 0);
    repeat (4) step();
    check("rmid_no_done", done_cnt - snap_done, 0);
    check("rmid_mc0", mem[8'hC0], 8'h05);
    check("rmid_mc1", mem[8'hC1], 8'h06);
    check("rmid_mc2", mem[8'hC2], 8'hEE);
    check("rmid_mc3", mem[8'hC3], 8'hEE);
    launch(8'hA2, 8'hC2, 8'd2);
    wait_done(cyc);
    check("rmid_after_latency", cyc, 4);
    check("rmid_after_checksum", checksum, 8'h0F);
    step();
    check("rmid_after_mc2", mem[8'hC2], 8'h07);
    check("rmid_after_mc3", mem[8'hC3], 8'h08);

    check("never_rd_and_wr", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
